// File: rtl/rgb_fade_ramp_pkg.sv
// Shared definitions for the RGB fill-factor path: FSM state encoding and
// default widths/limits used by the fade ramp, the PWM driver and the
// fill-factor registers.
package rgb_fade_ramp_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RAMP = 1'b1
  } state_t;

  localparam int unsigned DEF_BITS_NUM          = 8;
  localparam int unsigned DEF_FILL_FACTOR_MAX   = 255;
  localparam int unsigned DEF_STEP_PRESC_MODULO = 4;

  // Prescaler width covers STEP_PRESC_MODULO up to 1023.
  localparam int unsigned PRESC_W = 10;

endpackage

// File: rtl/fade_chan_step.sv
// One channel of the fade ramp: moves the current fill factor one LSB toward
// the (already clamped) target when step is high, otherwise holds it.
// Ports:
//   cur  - current fill factor
//   tgt  - clamped target fill factor
//   step - step event for this cycle
//   nxt  - fill factor after this cycle's (possible) step
//   eq   - nxt equals tgt
module fade_chan_step #(
  parameter int unsigned BITS_NUM = 8
) (
  input  logic [BITS_NUM-1:0] cur,
  input  logic [BITS_NUM-1:0] tgt,
  input  logic                step,
  output logic [BITS_NUM-1:0] nxt,
  output logic                eq
);

  // Moving only when strictly below/above the target means the value can
  // never pass it, so 0 and the clamp limit never wrap.
  always_comb begin
    nxt = cur;
    if (step) begin
      if (cur < tgt) begin
        nxt = cur + 1'b1;
      end else if (cur > tgt) begin
        nxt = cur - 1'b1;
      end
    end
    eq = (nxt == tgt);
  end

endmodule

// File: rtl/rgb_fade_ramp.sv
// Smoothing stage between the fill-factor registers and the RGB PWM driver.
// Fade mode ramps each channel one LSB per step tick toward its target;
// bypass mode registers the clamped targets directly.
// Ports:
//   CLK, CLR (async active-low reset), CE (1 ms tick pulse)
//   FADE_EN            - 1 fade, 0 bypass
//   R_TGT/G_TGT/B_TGT  - target fill factors (clamped to FILL_FACTOR_MAX)
//   R_FF/G_FF/B_FF     - fill factors driven to the PWM driver
//   BUSY               - ramp in progress
//   DONE               - one-cycle pulse when a ramp completes
module rgb_fade_ramp
  import rgb_fade_ramp_pkg::*;
#(
  parameter int unsigned BITS_NUM          = DEF_BITS_NUM,
  parameter int unsigned FILL_FACTOR_MAX   = DEF_FILL_FACTOR_MAX,
  parameter int unsigned STEP_PRESC_MODULO = DEF_STEP_PRESC_MODULO
) (
  input  logic                CLK,
  input  logic                CLR,
  input  logic                CE,
  input  logic                FADE_EN,
  input  logic [BITS_NUM-1:0] R_TGT,
  input  logic [BITS_NUM-1:0] G_TGT,
  input  logic [BITS_NUM-1:0] B_TGT,
  output logic [BITS_NUM-1:0] R_FF,
  output logic [BITS_NUM-1:0] G_FF,
  output logic [BITS_NUM-1:0] B_FF,
  output logic                BUSY,
  output logic                DONE
);

  localparam logic [BITS_NUM-1:0] FF_MAX     = BITS_NUM'(FILL_FACTOR_MAX);
  localparam logic [PRESC_W-1:0]  PRESC_LOAD = PRESC_W'(STEP_PRESC_MODULO - 1);

  state_t                     state, state_n;
  logic [PRESC_W-1:0]         presc, presc_n;
  logic                       done_q, done_n;
  logic [2:0][BITS_NUM-1:0]   tgt_raw, tgt_c, cur, nxt, cur_n;
  logic [2:0]                 eq;
  logic                       step;

  assign tgt_raw[0] = R_TGT;
  assign tgt_raw[1] = G_TGT;
  assign tgt_raw[2] = B_TGT;

  always_comb begin
    tgt_c = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      tgt_c[i] = (tgt_raw[i] > FF_MAX) ? FF_MAX : tgt_raw[i];
    end
  end

  assign step = (state == ST_RAMP) && FADE_EN && CE && (presc == '0);

  for (genvar g = 0; g < 3; g++) begin : g_chan
    fade_chan_step #(.BITS_NUM(BITS_NUM)) u_step (
      .cur  (cur[g]),
      .tgt  (tgt_c[g]),
      .step (step),
      .nxt  (nxt[g]),
      .eq   (eq[g])
    );
  end

  // eq is taken after the step, so one check covers both "all equal after a
  // step" and "targets moved onto the current values" (no step -> nxt = cur).
  always_comb begin
    state_n = state;
    presc_n = presc;
    done_n  = 1'b0;
    cur_n   = cur;
    if (!FADE_EN) begin
      state_n = ST_IDLE;
      cur_n   = tgt_c;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (!(&eq)) begin
            state_n = ST_RAMP;
            presc_n = PRESC_LOAD;
          end
        end
        ST_RAMP: begin
          cur_n = nxt;
          if (CE) begin
            presc_n = (presc == '0) ? PRESC_LOAD : presc - 1'b1;
          end
          if (&eq) begin
            state_n = ST_IDLE;
            done_n  = 1'b1;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state  <= ST_IDLE;
      presc  <= '0;
      done_q <= 1'b0;
      cur    <= '0;
    end else begin
      state  <= state_n;
      presc  <= presc_n;
      done_q <= done_n;
      cur    <= cur_n;
    end
  end

  assign R_FF = cur[0];
  assign G_FF = cur[1];
  assign B_FF = cur[2];
  assign BUSY = (state == ST_RAMP);
  assign DONE = done_q;

endmodule

// File: tb/tb_rgb_fade_ramp.sv
// Directed bench for rgb_fade_ramp with FILL_FACTOR_MAX = 200 and
// STEP_PRESC_MODULO = 4; inputs driven and outputs sampled 1 time unit
// after the rising clock edge.
module tb_rgb_fade_ramp;

  logic       CLK = 1'b0;
  logic       CLR;
  logic       CE;
  logic       FADE_EN;
  logic [7:0] R_TGT, G_TGT, B_TGT;
  logic [7:0] R_FF, G_FF, B_FF;
  logic       BUSY, DONE;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  rgb_fade_ramp #(
    .BITS_NUM          (8),
    .FILL_FACTOR_MAX   (200),
    .STEP_PRESC_MODULO (4)
  ) dut (
    .CLK     (CLK),
    .CLR     (CLR),
    .CE      (CE),
    .FADE_EN (FADE_EN),
    .R_TGT   (R_TGT),
    .G_TGT   (G_TGT),
    .B_TGT   (B_TGT),
    .R_FF    (R_FF),
    .G_FF    (G_FF),
    .B_FF    (B_FF),
    .BUSY    (BUSY),
    .DONE    (DONE)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rgb(input string tag, input logic [7:0] r, input logic [7:0] g,
                         input logic [7:0] b);
    chk({tag, ".r"}, {24'h0, R_FF}, {24'h0, r});
    chk({tag, ".g"}, {24'h0, G_FF}, {24'h0, g});
    chk({tag, ".b"}, {24'h0, B_FF}, {24'h0, b});
  endtask

  task automatic chk_st(input string tag, input logic busy, input logic done);
    chk({tag, ".busy"}, {31'h0, BUSY}, {31'h0, busy});
    chk({tag, ".done"}, {31'h0, DONE}, {31'h0, done});
  endtask

  task automatic clk1(input logic ce);
    CE = ce;
    @(posedge CLK);
    #1;
    CE = 1'b0;
  endtask

  // n CE pulses separated by idle cycles; returns just after the last CE edge.
  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      if (i > 0) clk1(1'b0);
      clk1(1'b1);
    end
  endtask

  task automatic set_tgt(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    R_TGT = r;
    G_TGT = g;
    B_TGT = b;
  endtask

  initial begin
    CLR = 1'b0;
    CE = 1'b0;
    FADE_EN = 1'b1;
    set_tgt(8'h80, 8'h80, 8'h80);

    // Reset held
    clk1(1'b0);
    clk1(1'b0);
    chk_rgb("rst", 8'h00, 8'h00, 8'h00);
    chk_st("rst", 1'b0, 1'b0);
    CLR = 1'b1;
    clk1(1'b0);
    chk_st("rst_rel", 1'b1, 1'b0);
    chk_rgb("rst_rel", 8'h00, 8'h00, 8'h00);

    // Abort of that ramp by bypass
    FADE_EN = 1'b0;
    clk1(1'b0);
    chk_rgb("abort0", 8'h80, 8'h80, 8'h80);
    chk_st("abort0", 1'b0, 1'b0);

    // Bypass
    set_tgt(8'h12, 8'h34, 8'h56);
    clk1(1'b0);
    chk_rgb("bypass", 8'h12, 8'h34, 8'h56);
    chk_st("bypass", 1'b0, 1'b0);

    // Fade up 0 -> 3 on red
    set_tgt(8'h00, 8'h00, 8'h00);
    clk1(1'b0);
    chk_rgb("zero", 8'h00, 8'h00, 8'h00);
    FADE_EN = 1'b1;
    R_TGT = 8'd3;
    clk1(1'b0);
    chk_st("up_start", 1'b1, 1'b0);
    chk_rgb("up_start", 8'h00, 8'h00, 8'h00);
    for (int k = 1; k <= 12; k++) begin
      clk1(1'b1);
      chk("up_r", {24'h0, R_FF}, k / 4);
      chk("up_done", {31'h0, DONE}, {31'h0, (k == 12)});
      chk("up_busy", {31'h0, BUSY}, {31'h0, (k != 12)});
      clk1(1'b0);
    end
    chk_st("up_after", 1'b0, 1'b0);
    chk_rgb("up_after", 8'd3, 8'h00, 8'h00);

    // Redirect: 0x40 heading for 0xFF, retargeted to 0x3E
    FADE_EN = 1'b0;
    set_tgt(8'h40, 8'h00, 8'h00);
    clk1(1'b0);
    chk_rgb("redir_load", 8'h40, 8'h00, 8'h00);
    FADE_EN = 1'b1;
    R_TGT = 8'hFF;
    clk1(1'b0);
    chk_st("redir_start", 1'b1, 1'b0);
    R_TGT = 8'h3E;
    pulses(4);
    chk_rgb("redir_s1", 8'h3F, 8'h00, 8'h00);
    chk_st("redir_s1", 1'b1, 1'b0);
    pulses(4);
    chk_rgb("redir_s2", 8'h3E, 8'h00, 8'h00);
    chk_st("redir_s2", 1'b0, 1'b1);
    clk1(1'b0);
    chk_st("redir_after", 1'b0, 1'b0);

    // Clamp at 200
    FADE_EN = 1'b0;
    R_TGT = 8'd198;
    clk1(1'b0);
    chk_rgb("clamp_load", 8'd198, 8'h00, 8'h00);
    FADE_EN = 1'b1;
    R_TGT = 8'hFF;
    clk1(1'b0);
    chk_st("clamp_start", 1'b1, 1'b0);
    pulses(4);
    chk_rgb("clamp_s1", 8'd199, 8'h00, 8'h00);
    pulses(4);
    chk_rgb("clamp_s2", 8'd200, 8'h00, 8'h00);
    chk_st("clamp_s2", 1'b0, 1'b1);
    pulses(8);
    chk_rgb("clamp_hold", 8'd200, 8'h00, 8'h00);
    chk_st("clamp_hold", 1'b0, 1'b0);
    FADE_EN = 1'b0;
    clk1(1'b0);
    chk_rgb("clamp_bypass", 8'd200, 8'h00, 8'h00);

    // No underflow below 0
    R_TGT = 8'd1;
    clk1(1'b0);
    chk_rgb("under_load", 8'd1, 8'h00, 8'h00);
    FADE_EN = 1'b1;
    R_TGT = 8'd0;
    clk1(1'b0);
    chk_st("under_start", 1'b1, 1'b0);
    pulses(4);
    chk_rgb("under_s1", 8'd0, 8'h00, 8'h00);
    chk_st("under_s1", 1'b0, 1'b1);
    pulses(4);
    chk_rgb("under_hold", 8'd0, 8'h00, 8'h00);
    chk_st("under_hold", 1'b0, 1'b0);

    // Independent channels: ramp length set by the farthest one
    FADE_EN = 1'b0;
    set_tgt(8'd5, 8'd5, 8'd5);
    clk1(1'b0);
    FADE_EN = 1'b1;
    set_tgt(8'd7, 8'd4, 8'd5);
    clk1(1'b0);
    chk_st("multi_start", 1'b1, 1'b0);
    pulses(4);
    chk_rgb("multi_s1", 8'd6, 8'd4, 8'd5);
    chk_st("multi_s1", 1'b1, 1'b0);
    pulses(4);
    chk_rgb("multi_s2", 8'd7, 8'd4, 8'd5);
    chk_st("multi_s2", 1'b0, 1'b1);

    // Targets move back onto the current values without a step
    FADE_EN = 1'b0;
    set_tgt(8'h10, 8'h00, 8'h00);
    clk1(1'b0);
    FADE_EN = 1'b1;
    R_TGT = 8'h20;
    clk1(1'b0);
    chk_st("settle_start", 1'b1, 1'b0);
    R_TGT = 8'h10;
    clk1(1'b0);
    chk_st("settle", 1'b0, 1'b1);
    chk_rgb("settle", 8'h10, 8'h00, 8'h00);
    clk1(1'b0);
    chk_st("settle_after", 1'b0, 1'b0);

    // Abort mid-ramp
    R_TGT = 8'h20;
    clk1(1'b0);
    chk_st("abort_start", 1'b1, 1'b0);
    pulses(4);
    chk_rgb("abort_s1", 8'h11, 8'h00, 8'h00);
    FADE_EN = 1'b0;
    clk1(1'b0);
    chk_rgb("abort", 8'h20, 8'h00, 8'h00);
    chk_st("abort", 1'b0, 1'b0);

    // Asynchronous reset mid-ramp
    FADE_EN = 1'b1;
    R_TGT = 8'h80;
    clk1(1'b0);
    chk_st("arst_start", 1'b1, 1'b0);
    pulses(4);
    chk_rgb("arst_s1", 8'h21, 8'h00, 8'h00);
    CLR = 1'b0;
    #1;
    chk_rgb("arst_async", 8'h00, 8'h00, 8'h00);
    chk_st("arst_async", 1'b0, 1'b0);
    clk1(1'b0);
    chk_rgb("arst_held", 8'h00, 8'h00, 8'h00);
    CLR = 1'b1;
    clk1(1'b0);
    chk_st("arst_rel", 1'b1, 1'b0);
    chk_rgb("arst_rel", 8'h00, 8'h00, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
